keypad_token_sequencer: RTL and testbench

- Sits between the keypad Decoder and the stack datapath.
- Qualifies raw per-frame key samples: debounces them, requires release between presses, and edge-detects one token per physical press.
- Builds a hex operand from digit keys.
- Issues PUSH and operator commands to the stack over a valid/ready handshake, sequencing an implicit PUSH before an operator when an entry is pending.

---
 rtl/keypad_token_sequencer.sv | 157 +++++++++++++++
 tb/tb_keypad_token_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_token_sequencer.sv
// Keypad token sequencer: debounces keypad frames, builds a hex operand and
// issues PUSH / operator commands to the stack over a valid/ready handshake.
module keypad_token_sequencer #(
   parameter  int DEBOUNCE_FRAMES = 4,
   parameter  int RELEASE_FRAMES  = 2,
   parameter  int OPERAND_W       = 16,
   localparam int DW              = $clog2(OPERAND_W/4) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 scan_tick,
   input  logic                 key_hit,
   input  logic [3:0]           key_code,
   output logic                 cmd_valid,
   input  logic                 cmd_ready,
   output logic [2:0]           cmd_op,
   output logic [OPERAND_W-1:0] cmd_data,
   output logic [OPERAND_W-1:0] entry_value,
   output logic [DW-1:0]        entry_digits,
   output logic                 entry_ovf,
   output logic                 busy
);

   localparam logic [3:0]    DEB     = 4'(DEBOUNCE_FRAMES);
   localparam logic [3:0]    REL     = 4'(RELEASE_FRAMES);
   localparam logic [DW-1:0] MAXD    = DW'(OPERAND_W/4);
   localparam logic [2:0]    OP_PUSH = 3'd0;

   typedef enum logic [2:0] {IDLE, QUAL, PUSH_ISSUE, OP_ISSUE, WAIT_REL} state_t;

   state_t     state;
   logic [3:0] cap_code;
   logic [3:0] qcnt;
   logic [3:0] rcnt;
   logic [2:0] pend_op;

   logic       hit_tick;
   logic       accept;
   logic [3:0] qnext;
   logic [2:0] key_op;

   assign hit_tick = scan_tick & key_hit;
   assign qnext    = qcnt + 4'd1;
   // A..D map onto ADD..DIV (1..4) through their low three bits.
   assign key_op   = key_code[2:0] - 3'd1;
   assign busy     = (state != IDLE);

   always_comb begin
      accept = 1'b0;
      case (state)
         IDLE:    accept = hit_tick && (DEB == 4'd1);
         QUAL:    accept = hit_tick && (key_code == cap_code) && (qnext == DEB);
         default: accept = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cap_code     <= '0;
         qcnt         <= '0;
         rcnt         <= '0;
         pend_op      <= '0;
         cmd_valid    <= 1'b0;
         cmd_op       <= '0;
         cmd_data     <= '0;
         entry_value  <= '0;
         entry_digits <= '0;
         entry_ovf    <= 1'b0;
      end else if (accept) begin
         qcnt <= '0;
         rcnt <= '0;
         if (key_code <= 4'd9) begin
            if (entry_digits < MAXD) begin
               entry_value  <= OPERAND_W'({entry_value, key_code});
               entry_digits <= entry_digits + DW'(1);
            end else begin
               entry_ovf <= 1'b1;
            end
            state <= WAIT_REL;
         end else if (key_code == 4'hE) begin
            entry_value  <= '0;
            entry_digits <= '0;
            entry_ovf    <= 1'b0;
            state        <= WAIT_REL;
         end else if (key_code == 4'hF) begin
            pend_op   <= '0;
            cmd_valid <= 1'b1;
            cmd_op    <= OP_PUSH;
            cmd_data  <= entry_value;
            state     <= PUSH_ISSUE;
         end else if (entry_digits != '0) begin
            // Pending entry: push it first, then issue the operator.
            pend_op   <= key_op;
            cmd_valid <= 1'b1;
            cmd_op    <= OP_PUSH;
            cmd_data  <= entry_value;
            state     <= PUSH_ISSUE;
         end else begin
            pend_op   <= '0;
            cmd_valid <= 1'b1;
            cmd_op    <= key_op;
            cmd_data  <= '0;
            state     <= OP_ISSUE;
         end
      end else begin
         case (state)
            IDLE: if (hit_tick) begin
               cap_code <= key_code;
               qcnt     <= 4'd1;
               state    <= QUAL;
            end
            QUAL: if (scan_tick) begin
               if (hit_tick && key_code == cap_code) begin
                  qcnt <= qnext;
               end else begin
                  qcnt  <= '0;
                  state <= IDLE;
               end
            end
            PUSH_ISSUE: if (cmd_ready) begin
               entry_value  <= '0;
               entry_digits <= '0;
               entry_ovf    <= 1'b0;
               if (pend_op != '0) begin
                  cmd_op   <= pend_op;
                  cmd_data <= '0;
                  state    <= OP_ISSUE;
               end else begin
                  cmd_valid <= 1'b0;
                  rcnt      <= '0;
                  state     <= WAIT_REL;
               end
            end
            OP_ISSUE: if (cmd_ready) begin
               cmd_valid <= 1'b0;
               cmd_op    <= '0;
               pend_op   <= '0;
               rcnt      <= '0;
               state     <= WAIT_REL;
            end
            WAIT_REL: if (scan_tick) begin
               if (key_hit) begin
                  rcnt <= '0;
               end else if (rcnt + 4'd1 == REL) begin
                  rcnt  <= '0;
                  state <= IDLE;
               end else begin
                  rcnt <= rcnt + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_token_sequencer.sv
// Bench for keypad_token_sequencer: table-driven entry checks plus a command
// scoreboard fed when keys are driven and drained on each handshake transfer.
module tb_keypad_token_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_tick = 1'b0;
   logic        key_hit = 1'b0;
   logic [3:0]  key_code = '0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b1;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_data;
   logic [15:0] entry_value;
   logic [2:0]  entry_digits;
   logic        entry_ovf;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int xfers  = 0;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] data;
   } cmd_t;
   cmd_t sb[$];

   typedef struct {
      logic [3:0]  code;
      int          frames;
      logic [15:0] val;
      logic [2:0]  digs;
      logic        ovf;
   } vec_t;
   vec_t vecs[9];

   keypad_token_sequencer dut (
      .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick), .key_hit(key_hit),
      .key_code(key_code), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .entry_value(entry_value),
      .entry_digits(entry_digits), .entry_ovf(entry_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Transfer monitor: inputs change just after posedge, so valid&ready at the
   // falling edge is exactly what the next rising edge will transfer.
   always @(negedge clk) begin
      if (rst_n && cmd_valid && cmd_ready) begin
         xfers++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cmd: got op %0d data 0x%0h, expected none", cmd_op, cmd_data);
         end else begin
            cmd_t e;
            e = sb.pop_front();
            chk("cmd_op", {29'd0, cmd_op}, {29'd0, e.op});
            chk("cmd_data", {16'd0, cmd_data}, {16'd0, e.data});
         end
      end
   end

   task automatic tick(input logic hit, input logic [3:0] code);
      @(posedge clk); #1;
      scan_tick = 1'b1; key_hit = hit; key_code = code;
      @(posedge clk); #1;
      scan_tick = 1'b0; key_hit = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic press(input logic [3:0] code, input int n);
      repeat (n) tick(1'b1, code);
      repeat (3) tick(1'b0, 4'h0);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      chk(name, sb.size(), 0);
   endtask

   task automatic check_entry(input string name, input logic [15:0] v,
                              input logic [2:0] d, input logic o);
      @(negedge clk);
      chk({name, "_value"}, {16'd0, entry_value}, {16'd0, v});
      chk({name, "_digits"}, {29'd0, entry_digits}, {29'd0, d});
      chk({name, "_ovf"}, {31'd0, entry_ovf}, {31'd0, o});
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      vecs[0] = '{4'h1, 4,  16'h0001, 3'd1, 1'b0};
      vecs[1] = '{4'h2, 4,  16'h0012, 3'd2, 1'b0};
      vecs[2] = '{4'h3, 20, 16'h0123, 3'd3, 1'b0};
      vecs[3] = '{4'h4, 4,  16'h1234, 3'd4, 1'b0};
      vecs[4] = '{4'h5, 4,  16'h1234, 3'd4, 1'b1};
      vecs[5] = '{4'hE, 4,  16'h0000, 3'd0, 1'b0};
      vecs[6] = '{4'h9, 6,  16'h0009, 3'd1, 1'b0};
      vecs[7] = '{4'hE, 4,  16'h0000, 3'd0, 1'b0};
      vecs[8] = '{4'h4, 4,  16'h0004, 3'd1, 1'b0};

      #3;
      chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_digits", {29'd0, entry_digits}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Bounce: three frames of 5 then a gap is not a press.
      repeat (3) tick(1'b1, 4'h5);
      repeat (3) tick(1'b0, 4'h0);
      check_entry("bounce", 16'h0, 3'd0, 1'b0);

      foreach (vecs[i]) begin
         press(vecs[i].code, vecs[i].frames);
         check_entry($sformatf("vec%0d", i), vecs[i].val, vecs[i].digs, vecs[i].ovf);
      end

      // Implicit push under backpressure: entry is 0x0004, add digit 2.
      press(4'h2, 4);
      check_entry("pre_push", 16'h0042, 3'd2, 1'b0);
      cmd_ready = 1'b0;
      sb.push_back('{3'd0, 16'h0042});
      sb.push_back('{3'd1, 16'h0000});
      repeat (4) tick(1'b1, 4'hA);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, cmd_valid}, 32'd1);
         chk("stall_op", {29'd0, cmd_op}, 32'd0);
         chk("stall_data", {16'd0, cmd_data}, 32'h0042);
      end
      xfers = 0;
      @(posedge clk); #1 cmd_ready = 1'b1;
      wait_drain("push_add_drain");
      repeat (3) tick(1'b0, 4'h0);
      chk("push_add_xfers", xfers, 2);
      check_entry("post_push", 16'h0, 3'd0, 1'b0);

      // Empty entry: operator issues alone; ENTER pushes zero.
      sb.push_back('{3'd3, 16'h0000});
      press(4'hC, 4);
      wait_drain("mul_drain");
      sb.push_back('{3'd0, 16'h0000});
      press(4'hF, 4);
      wait_drain("enter_drain");
      check_entry("post_enter", 16'h0, 3'd0, 1'b0);

      // Reset in the middle of a stalled handshake discards the command.
      press(4'h7, 4);
      cmd_ready = 1'b0;
      sb.push_back('{3'd0, 16'h0007});
      repeat (4) tick(1'b1, 4'hF);
      @(negedge clk);
      chk("pre_rst_valid", {31'd0, cmd_valid}, 32'd1);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("midrst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("midrst_value", {16'd0, entry_value}, 32'd0);
      chk("midrst_digits", {29'd0, entry_digits}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      sb.delete();
      xfers = 0;
      @(posedge clk); #1 rst_n = 1'b1; cmd_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("postrst_xfers", xfers, 0);
      chk("postrst_valid", {31'd0, cmd_valid}, 32'd0);

      chk("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
